switch_port_rr_mc: RTL and testbench

Parametrised next-generation switch egress port. It accepts packets of {source mask, target mask, data} over a valid/ready handshake into a small input FIFO. Each packet is fanned out as multicast, one destination per output beat, in round-robin destination order, with the source never echoed back to itself. The block sits between the ingress crossbar and the per-port egress links, and adds backpressure on both sides plus a drop counter.

---
 rtl/switch_port_rr_mc.sv | 212 +++++++++++++++++++++
 tb/tb_switch_port_rr_mc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_port_rr_mc.sv
// switch_port_rr_mc
//
// Egress port of the switch. Packets of {source mask, target mask, data} are
// accepted over a valid/ready handshake into a small input FIFO. Each packet
// is then replayed as one output beat per destination. Destinations are
// visited in round-robin order, and the source port is never echoed back to
// itself. A packet whose effective target set is empty is dropped and counted.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   ingress handshake (in_ready = FIFO not full)
//   in_source/in_target source mask and multicast target mask
//   in_data             payload
//   out_valid/out_ready egress handshake (out_valid is registered)
//   out_source          source mask of the packet being delivered
//   out_target          one-hot destination of the current beat
//   out_data            payload of the packet being delivered
//   fifo_count          input FIFO occupancy
//   drop_cnt            saturating count of dropped packets
module switch_port_rr_mc #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_PORTS-1:0]          in_source,
    input  logic [NUM_PORTS-1:0]          in_target,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_PORTS-1:0]          out_source,
    output logic [NUM_PORTS-1:0]          out_target,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;

    // First set bit of mask, scanning upward from start and wrapping at
    // NUM_PORTS (explicit wrap so non-power-of-two port counts work).
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_PORTS-1:0] mask,
                                              input logic [PW-1:0] start);
        logic [PW-1:0] idx;
        logic          found;
        int            j;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = int'(start) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!found && mask[PW'(j)]) begin
                found = 1'b1;
                idx   = PW'(j);
            end
        end
        return idx;
    endfunction

    function automatic logic [NUM_PORTS-1:0] to_onehot(input logic [PW-1:0] idx);
        logic [NUM_PORTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
        return (idx == PW'(NUM_PORTS - 1)) ? '0 : idx + PW'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Input FIFO storage and pointers
    logic [NUM_PORTS-1:0] src_mem [FIFO_DEPTH];
    logic [NUM_PORTS-1:0] tgt_mem [FIFO_DEPTH];
    logic [DATA_W-1:0]    dat_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;

    // Packet engine state
    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] src_r, pending_r;
    logic [DATA_W-1:0]    dat_r;
    logic [PW-1:0]        rr_ptr, cur_idx;

    logic [NUM_PORTS-1:0] eff;
    logic                 accept, push, drop, pop, hs, arb_any, more;
    logic [NUM_PORTS-1:0] pend_after;
    logic [PW-1:0]        arb_idx, rr_after, send_idx;

    assign in_ready = (fifo_count != (AW+1)'(FIFO_DEPTH));
    assign eff      = in_target & ~in_source;
    assign accept   = in_valid && in_ready;
    assign push     = accept && (eff != '0);
    assign drop     = accept && (eff == '0);

    assign hs         = out_valid && out_ready;
    assign arb_any    = (pending_r != '0);
    assign arb_idx    = rr_pick(pending_r, rr_ptr);
    assign pend_after = pending_r & ~out_target;
    assign more       = (pend_after != '0);
    assign rr_after   = wrap_inc(cur_idx);
    // Next destination is resolved in the handshake cycle so beats stay back-to-back.
    assign send_idx   = rr_pick(pend_after, rr_after);

    // ---- Ingress: FIFO write, occupancy and drop counting ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_cnt   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                src_mem[i] <= '0;
                tgt_mem[i] <= '0;
                dat_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                src_mem[wr_ptr] <= in_source;
                tgt_mem[wr_ptr] <= eff;
                dat_mem[wr_ptr] <= in_data;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop) drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // ---- Packet engine FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_d = ARB;
                end
            end
            ARB:     state_d = arb_any ? SEND : IDLE;
            SEND:    if (hs && !more) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- Egress: packet registers and output beat ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_r      <= '0;
            pending_r  <= '0;
            dat_r      <= '0;
            rr_ptr     <= '0;
            cur_idx    <= '0;
            out_valid  <= 1'b0;
            out_source <= '0;
            out_target <= '0;
            out_data   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        src_r     <= src_mem[rd_ptr];
                        pending_r <= tgt_mem[rd_ptr];
                        dat_r     <= dat_mem[rd_ptr];
                    end
                end
                ARB: begin
                    if (arb_any) begin
                        out_target <= to_onehot(arb_idx);
                        cur_idx    <= arb_idx;
                        out_source <= src_r;
                        out_data   <= dat_r;
                        out_valid  <= 1'b1;
                    end
                end
                SEND: begin
                    if (hs) begin
                        pending_r <= pend_after;
                        rr_ptr    <= rr_after;
                        if (more) begin
                            out_target <= to_onehot(send_idx);
                            cur_idx    <= send_idx;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_port_rr_mc.sv
module tb_switch_port_rr_mc;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int FD = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NP-1:0] in_source = '0;
    logic [NP-1:0] in_target = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [NP-1:0] out_source;
    logic [NP-1:0] out_target;
    logic [DW-1:0] out_data;
    logic [$clog2(FD):0] fifo_count;
    logic [CW-1:0] drop_cnt;

    switch_port_rr_mc #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_source(in_source), .in_target(in_target), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_source(out_source), .out_target(out_target), .out_data(out_data),
        .fifo_count(fifo_count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0] src;
        logic [NP-1:0] tgt;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic [NP-1:0] src;
        logic [NP-1:0] tgt;
        logic [DW-1:0] data;
        int            nb;
        logic [15:0]   beats;   // first beat in [15:12]
    } vec_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_err = 0;
    int    mrr = 0;
    int    exp_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk destinations from the model RR pointer, one beat each.
    task automatic model_pkt(input logic [NP-1:0] src, input logic [NP-1:0] tgt,
                             input logic [DW-1:0] data, input bit enq);
        logic [NP-1:0] pend;
        logic [NP-1:0] oh;
        int            p;
        beat_t         b;
        pend = tgt & ~src;
        if (pend == '0) begin
            if (exp_drop < 255) exp_drop++;
            return;
        end
        p = mrr;
        while (pend != '0) begin
            oh = NP'(1) << p;
            if ((pend & oh) != '0) begin
                b.src = src; b.tgt = oh; b.data = data;
                if (enq) exp_q.push_back(b);
                pend = pend & ~oh;
                mrr  = (p + 1) % NP;
            end
            p = (p + 1) % NP;
        end
    endtask

    // Present a packet and hold it until accepted (bounded).
    task automatic send_pkt(input logic [NP-1:0] src, input logic [NP-1:0] tgt,
                            input logic [DW-1:0] data, input bit enq);
        logic rdy;
        bit   acc;
        acc = 0;
        in_source = src; in_target = tgt; in_data = data; in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin acc = 1; break; end
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++; n_err++;
            $display("FAIL accept_timeout: got not-accepted expected accepted");
        end else begin
            model_pkt(src, tgt, data, enq);
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !out_valid && fifo_count == '0) break;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        check("drain_idle", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 50; c++) begin
            if (out_valid) break;
            @(posedge clk); #1;
        end
        check("wait_valid", {31'd0, out_valid}, 32'd1);
    endtask

    // Scoreboard: a beat is committed at the next edge when valid && ready.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL unexpected_beat: got tgt=%b data=%h expected none", out_target, out_data);
            end else begin
                e = exp_q.pop_front();
                check("beat", 32'({out_source, out_target, out_data}), 32'({e.src, e.tgt, e.data}));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[8];
        beat_t       b;
        logic [15:0] bs;
        logic [31:0] snap;

        tbl[0] = '{src: 4'b0001, tgt: 4'b1000, data: 8'h11, nb: 1, beats: 16'h8000};
        tbl[1] = '{src: 4'b0010, tgt: 4'b1111, data: 8'h22, nb: 3, beats: 16'h1480};
        tbl[2] = '{src: 4'b0001, tgt: 4'b0010, data: 8'h33, nb: 1, beats: 16'h2000};
        tbl[3] = '{src: 4'b1000, tgt: 4'b0011, data: 8'h44, nb: 2, beats: 16'h1200};
        tbl[4] = '{src: 4'b1000, tgt: 4'b0101, data: 8'h55, nb: 2, beats: 16'h4100};
        tbl[5] = '{src: 4'b0100, tgt: 4'b0100, data: 8'h66, nb: 0, beats: 16'h0000};
        tbl[6] = '{src: 4'b0011, tgt: 4'b0111, data: 8'h77, nb: 1, beats: 16'h4000};
        tbl[7] = '{src: 4'b0000, tgt: 4'b1001, data: 8'h88, nb: 2, beats: 16'h8100};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_out", 32'({out_valid, out_source, out_target, out_data}), 32'd0);
        check("rst_count_drop", 32'({fifo_count, drop_cnt}), 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Unicast with latency check
        in_source = 4'b0001; in_target = 4'b0100; in_data = 8'hA5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_pkt(4'b0001, 4'b0100, 8'hA5, 1);
        check("uni_count_after_push", 32'(fifo_count), 32'd1);
        @(negedge clk);
        check("uni_valid_e0", {31'd0, out_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("uni_valid_e1", {31'd0, out_valid}, 32'd0);
        check("uni_popped", 32'(fifo_count), 32'd0);
        @(posedge clk); @(negedge clk);
        check("uni_valid_e2", {31'd0, out_valid}, 32'd1);
        wait_drain();
        check("uni_hold", 32'({out_source, out_target, out_data}), 32'({4'b0001, 4'b0100, 8'hA5}));

        // Table: multicast, self-mask, RR fairness, drop
        for (int i = 0; i < 8; i++) begin
            send_pkt(tbl[i].src, tbl[i].tgt, tbl[i].data, 0);
            bs = tbl[i].beats;
            for (int k = 0; k < tbl[i].nb; k++) begin
                b.src = tbl[i].src; b.tgt = bs[15:12]; b.data = tbl[i].data;
                exp_q.push_back(b);
                bs = bs << 4;
            end
        end
        wait_drain();
        check("drop_one", 32'(drop_cnt), 32'd1);

        // Egress backpressure, twice within one packet
        out_ready = 1'b0;
        send_pkt(4'b0001, 4'b1110, 8'hC3, 1);
        wait_valid();
        for (int r = 0; r < 2; r++) begin
            snap = 32'({out_source, out_target, out_data});
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                check("bp_stable", 32'({out_valid, out_source, out_target, out_data}), {15'd0, 1'b1, snap[15:0]});
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        out_ready = 1'b1;
        wait_drain();

        // FIFO full, including push and pop on the same edge
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_pkt(4'b0001, 4'b0010 << (i % 3), 8'(8'h10 + i), 1);
            case (i)
                0, 1:    check("full_count", 32'(fifo_count), 32'd1);
                2:       check("full_count", 32'(fifo_count), 32'd2);
                3:       check("full_count", 32'(fifo_count), 32'd3);
                default: check("full_count", 32'(fifo_count), 32'd4);
            endcase
        end
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        in_source = 4'b0010; in_target = 4'b1001; in_data = 8'h16; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("full_wait", 32'({in_ready, fifo_count}), 32'd4);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send_pkt(4'b0010, 4'b1001, 8'h16, 1);
        wait_drain();
        check("full_empty", 32'(fifo_count), 32'd0);

        // Drops and saturation
        send_pkt(4'b0100, 4'b0100, 8'h99, 1);
        check("drop_two", 32'(drop_cnt), 32'(exp_drop));
        for (int i = 0; i < 258; i++) send_pkt(4'b1000, 4'b1000, 8'(i), 1);
        check("drop_sat", 32'(drop_cnt), 32'(exp_drop));
        check("drop_sat_ff", 32'(drop_cnt), 32'hFF);

        // Asynchronous reset mid-SEND
        out_ready = 1'b0;
        send_pkt(4'b0001, 4'b1110, 8'h5A, 1);
        send_pkt(4'b0010, 4'b0001, 8'h5B, 1);
        wait_valid();
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_count_drop", 32'({fifo_count, drop_cnt}), 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        mrr = 0;
        exp_drop = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_pkt(4'b0001, 4'b0110, 8'h3C, 1);
        wait_drain();
        check("post_rst_drop", 32'(drop_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
